// File: rtl/clk_tap_select.sv
// Glitch-free selector over eight divided-clock taps with a timed-out forced switch.
// Optional rising-edge counter on clk_out is built when CLK_TAP_SELECT_EDGE_CNT_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | clk_out follows taps[cur_sel]; requests accepted here only
// WAIT_LOW | old tap still drives clk_out; waiting for old/new common low
// SWITCH   | one cycle with clk_out held low, then back to IDLE on new tap
module clk_tap_select #(
    parameter logic [2:0]  RESET_SEL = 3'd0,
    parameter logic [15:0] TIMEOUT   = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  taps,
    input  logic        en,
    input  logic        sel_valid,
    input  logic [2:0]  sel,
    output logic        sel_ready,
    output logic        done,
    output logic [2:0]  cur_sel,
    output logic        clk_out,
    output logic        out_rise,
    output logic        timeout_err,
    input  logic        cnt_clr,
    output logic [15:0] edge_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        SWITCH   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cur_sel;
    logic [2:0]  w_cur_sel_nxt;
    logic [2:0]  r_new_sel;
    logic [2:0]  w_new_sel_nxt;
    logic [15:0] r_timer;
    logic [15:0] w_timer_nxt;
    logic        r_clk_out;
    logic        w_clk_out_nxt;
    logic        r_clk_out_d;
    logic        r_out_rise;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_terr;
    logic        w_terr_nxt;
    logic        w_accept;
    logic        w_common_low;
    logic        w_tmo;

    assign w_accept     = sel_valid && (r_state == IDLE);
    assign w_common_low = ~taps[r_cur_sel] & ~taps[r_new_sel];
    assign w_tmo        = (r_timer == (TIMEOUT - 16'd1));

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_sel_nxt = r_cur_sel;
        w_new_sel_nxt = r_new_sel;
        w_timer_nxt   = r_timer;
        w_done_nxt    = 1'b0;
        w_terr_nxt    = r_terr;
        w_clk_out_nxt = en & taps[r_cur_sel];
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (sel == r_cur_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_new_sel_nxt = sel;
                        w_timer_nxt   = 16'd0;
                        w_state_nxt   = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                w_timer_nxt = r_timer + 16'd1;
                // Common low takes priority so a coincident timeout is not flagged.
                if (w_common_low || w_tmo) begin
                    w_terr_nxt    = r_terr | ~w_common_low;
                    w_cur_sel_nxt = r_new_sel;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = SWITCH;
                end
            end
            SWITCH: begin
                w_clk_out_nxt = 1'b0;
                w_timer_nxt   = 16'd0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_sel   <= RESET_SEL;
            r_new_sel   <= RESET_SEL;
            r_timer     <= 16'd0;
            r_clk_out   <= 1'b0;
            r_clk_out_d <= 1'b0;
            r_out_rise  <= 1'b0;
            r_done      <= 1'b0;
            r_terr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_new_sel   <= w_new_sel_nxt;
            r_timer     <= w_timer_nxt;
            r_clk_out   <= w_clk_out_nxt;
            r_clk_out_d <= r_clk_out;
            r_out_rise  <= r_clk_out & ~r_clk_out_d;
            r_done      <= w_done_nxt;
            r_terr      <= w_terr_nxt;
        end
    end

`ifdef CLK_TAP_SELECT_EDGE_CNT_EN
    logic [15:0] r_edge_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_edge_cnt <= 16'd0;
        end else if (r_out_rise) begin
            r_edge_cnt <= r_edge_cnt + 16'd1;
        end
    end

    assign edge_cnt = r_edge_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign edge_cnt         = 16'd0;
`endif

    assign sel_ready   = (r_state == IDLE) && !rst;
    assign done        = r_done;
    assign cur_sel     = r_cur_sel;
    assign clk_out     = r_clk_out;
    assign out_rise    = r_out_rise;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_clk_tap_select.sv
// Scoreboard bench for clk_tap_select: taps come from a free-running divider,
// request outcomes are predicted from the tap waveform and checked by a monitor.
module tb_clk_tap_select;

    localparam logic [2:0]  RSEL  = 3'd0;
    localparam logic [15:0] TMO   = 16'd64;
    localparam int          TMO_I = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  taps;
    logic        en;
    logic        sel_valid;
    logic [2:0]  sel;
    logic        sel_ready;
    logic        done;
    logic [2:0]  cur_sel;
    logic        clk_out;
    logic        out_rise;
    logic        timeout_err;
    logic        cnt_clr;
    logic [15:0] edge_cnt;
    logic [7:0]  mask;

    clk_tap_select #(.RESET_SEL(RSEL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .taps(taps), .en(en), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(sel_ready), .done(done), .cur_sel(cur_sel),
        .clk_out(clk_out), .out_rise(out_rise), .timeout_err(timeout_err),
        .cnt_clr(cnt_clr), .edge_cnt(edge_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural divider: tap i is bit i of a free-running cycle count.
    int unsigned pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;
    assign taps = pcyc[7:0] | mask;

    logic       rst_s = 1'b1, en_s = 1'b0, clr_s = 1'b0;
    logic [7:0] tv_s = 8'd0;
    always @(posedge clk) begin
        rst_s <= rst;
        en_s  <= en;
        clr_s <= cnt_clr;
        tv_s  <= taps;
    end

    typedef struct {
        int unsigned cyc;
        logic [2:0]  sel;
        bit          to;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] cur_model = RSEL;
    logic       exp_terr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Reference: first WAIT_LOW cycle k where both taps read low, else forced at TIMEOUT.
    function automatic void predict(input logic [2:0] o, input logic [2:0] n,
                                    input int unsigned p0, input logic [7:0] m,
                                    output int lat, output bit to);
        logic [7:0] t;
        lat = TMO_I;
        to  = 1'b1;
        if (o == n) begin
            lat = 0;
            to  = 1'b0;
            return;
        end
        for (int k = 1; k <= TMO_I; k++) begin
            t = 8'(p0 + k) | m;
            if (!t[o] && !t[n]) begin
                lat = k;
                to  = 1'b0;
                return;
            end
        end
    endfunction

    initial begin : monitor
        logic        co1, co2, exp_rise, prev_rise, exp_co;
        logic [15:0] exp_cnt;
        bit          sw_zero;
        exp_t        r;
        co1 = 0; co2 = 0; prev_rise = 0; exp_cnt = 0; sw_zero = 0;
        forever begin
            @(posedge clk);
            #1;
            exp_rise = rst_s ? 1'b0 : (co1 & ~co2);
            chk("out_rise", out_rise, exp_rise);
`ifdef CLK_TAP_SELECT_EDGE_CNT_EN
            if (rst_s || clr_s) exp_cnt = 16'd0;
            else if (prev_rise) exp_cnt = exp_cnt + 16'd1;
`endif
            chk("edge_cnt", edge_cnt, exp_cnt);
            if (rst_s) begin
                q.delete();
                sw_zero   = 0;
                cur_model = RSEL;
                exp_terr  = 1'b0;
                chk("rst_clk_out", clk_out, 0);
                chk("rst_cur_sel", cur_sel, RSEL);
                chk("rst_done", done, 0);
                chk("rst_timeout_err", timeout_err, 0);
                chk("rst_sel_ready", sel_ready, 0);
            end else begin
                exp_co = sw_zero ? 1'b0 : (en_s & tv_s[cur_model]);
                chk(sw_zero ? "switch_gap" : "clk_out", clk_out, exp_co);
                sw_zero = 0;
                if (done) begin
                    if (q.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        r = q.pop_front();
                        chk("done_cycle", pcyc, r.cyc);
                        if (r.to) exp_terr = 1'b1;
                        if (r.sel != cur_model) sw_zero = 1;
                        cur_model = r.sel;
                    end
                end else if (q.size() != 0 && pcyc > q[0].cyc) begin
                    chk("done_late", pcyc, q[0].cyc);
                    r = q.pop_front();
                end
                chk("cur_sel", cur_sel, cur_model);
                chk("timeout_err", timeout_err, exp_terr);
            end
            co2 = co1;
            co1 = clk_out;
            prev_rise = exp_rise;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic [2:0] s);
        int         b, lat;
        bit         to;
        logic [2:0] old;
        exp_t       e;
        b = 0;
        while (!sel_ready && b < 200) begin
            tick();
            b++;
        end
        if (!sel_ready) begin
            chk("ready_wait", sel_ready, 1);
            return;
        end
        old = cur_model;
        predict(old, s, pcyc, mask, lat, to);
        e.cyc = pcyc + 1 + lat;
        e.sel = s;
        e.to  = to;
        q.push_back(e);
        sel_valid = 1'b1;
        sel       = s;
        tick();
        sel_valid = 1'b0;
        if (s != old) chk("ready_low", sel_ready, 0);
        b = 0;
        while (q.size() != 0 && b < TMO_I + 20) begin
            sel_valid = 1'b0;
            if (!sel_ready && $urandom_range(0, 3) == 0) begin
                sel_valid = 1'b1;
                sel       = 3'($urandom_range(0, 7));
            end
            tick();
            b++;
        end
        sel_valid = 1'b0;
        if (q.size() != 0) chk("done_wait", q.size(), 0);
    endtask

    initial begin : stimulus
        int b;
        rst = 1'b1; en = 1'b1; sel_valid = 1'b0; sel = 3'd0; cnt_clr = 1'b0; mask = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("ready_after_reset", sel_ready, 1);
        repeat (10) tick();

        // 0 -> 7 aligned so the common low arrives well before the timeout
        while ((pcyc % 256) != 240) tick();
        req(3'd7);
        repeat (5) tick();
        req(3'd3);
        req(3'd3);

        // common low lands on the exact timeout cycle: must not flag an error
        req(3'd6);
        while ((pcyc % 256) != 192) tick();
        req(3'd7);

        // forced switch: tap 0 held high
        req(3'd0);
        mask = 8'h01;
        req(3'd3);
        mask = 8'h00;
        repeat (5) tick();

`ifdef CLK_TAP_SELECT_EDGE_CNT_EN
        req(3'd1);
        en = 1'b1;
        repeat (4) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        repeat (400) tick();
        chk("edge_cnt_400", edge_cnt, 100);
        b = 0;
        while (!out_rise && b < 8) begin
            tick();
            b++;
        end
        chk("rise_seen", out_rise, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_beats_rise", edge_cnt, 0);
`endif

        // reset in the middle of a 0 -> 5 wait
        req(3'd0);
        while ((pcyc % 64) != 32) tick();
        sel_valid = 1'b1;
        sel       = 3'd5;
        tick();
        sel_valid = 1'b0;
        chk("ready_low_wait", sel_ready, 0);
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("ready_after_abort", sel_ready, 1);
        chk("cur_sel_after_abort", cur_sel, RSEL);
        repeat (40) tick();

        for (int i = 0; i < 40; i++) begin
            int idle;
            idle = $urandom_range(0, 12);
            for (int j = 0; j < idle; j++) begin
                en      = ($urandom_range(0, 7) != 0);
                cnt_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
            cnt_clr = 1'b0;
            mask = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            req(3'($urandom_range(0, 7)));
            mask = 8'd0;
        end

        en = 1'b1;
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/clk_tap_select.md
CLK_TAP_SELECT -- requirements
Module: clk_tap_select

Interface
REQ-001 Parameter: RESET_SEL, default 3'd0, tap index selected out of reset.
REQ-002 Parameter: TIMEOUT, default 16'd1024, maximum WAIT_LOW cycles before a forced switch; legal range 2..65535.
REQ-003 Port: clk  input  1  single clock; all logic on posedge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: taps  input  8  divided-clock taps from the divider stage (bit i = divide-by-2^(i+1)), already in the clk domain, sampled without synchronizer.
REQ-006 Port: en  input  1  output enable; low forces clk_out to 0.
REQ-007 Port: sel_valid  input  1  new tap select request.
REQ-008 Port: sel  input  3  requested tap index.
REQ-009 Port: sel_ready  output  1  block can accept a request.
REQ-010 Port: done  output  1  one-cycle pulse when a request completes.
REQ-011 Port: cur_sel  output  3  currently active tap index.
REQ-012 Port: clk_out  output  1  registered, glitch-free selected tap.
REQ-013 Port: out_rise  output  1  one-cycle pulse on each 0->1 of clk_out.
REQ-014 Port: timeout_err  output  1  sticky flag, forced switch occurred.
REQ-015 Port: cnt_clr  input  1  clears edge_cnt.
REQ-016 Port: edge_cnt  output  16  count of clk_out rising edges.

Function
REQ-017 States: IDLE, WAIT_LOW, SWITCH; sel_ready=1 only in IDLE.
REQ-018 Request accepted on sel_valid && sel_ready; requests outside IDLE are ignored, never queued.
REQ-019 IDLE: clk_out <= en & taps[cur_sel] (one-cycle latency).
REQ-020 IDLE accept with sel==cur_sel: stay IDLE, done=1 next cycle, clk_out unaffected.
REQ-021 IDLE accept with sel!=cur_sel: latch new_sel, clear timer, go to WAIT_LOW.
REQ-022 WAIT_LOW: clk_out keeps following old tap; timer increments each cycle.
REQ-023 WAIT_LOW, taps[cur_sel]==0 && taps[new_sel]==0 in the same cycle: cur_sel<=new_sel, go to SWITCH.
REQ-024 WAIT_LOW, timer==TIMEOUT-1 with no common-low cycle: timeout_err<=1, cur_sel<=new_sel, go to SWITCH.
REQ-025 If common-low and timeout occur in the same cycle, common-low wins and timeout_err is unchanged.
REQ-026 SWITCH lasts one cycle: clk_out<=0, done<=1, then IDLE; clk_out follows the new tap from the next cycle.
REQ-027 clk_out never produces a high or low phase shorter than the shorter half-period of the old and new taps (forced switch excepted).
REQ-028 en low: clk_out<=0 next cycle; FSM and handshake unaffected.
REQ-029 out_rise = clk_out & ~clk_out_prev, registered, one cycle after the clk_out rise.
REQ-030 timeout_err is cleared only by reset.

Reset
REQ-031 rst high: state=IDLE, cur_sel=RESET_SEL, clk_out=0, out_rise=0, done=0, timeout_err=0, edge_cnt=0, timer=0, sel_ready=0; sel_ready=1 on the first cycle after rst falls.
REQ-032 rst asserted during WAIT_LOW or SWITCH aborts the switch and discards the pending new_sel.

Configuration
REQ-033 Macro CLK_TAP_SELECT_EDGE_CNT_EN defined: edge_cnt increments on out_rise and wraps 0xFFFF->0; cnt_clr sets it to 0; cnt_clr wins over a same-cycle out_rise.
REQ-034 Macro undefined: no counter logic, edge_cnt tied to 16'd0, cnt_clr ignored.

Verification
REQ-035 Taps from a behavioural divider, reset, RESET_SEL=0, en=1 -> clk_out period 2 cycles, out_rise every 2nd cycle, sel_ready=1.
REQ-036 Request sel=7 from sel=0 -> sel_ready low, done within 256 cycles, cur_sel=7, clk_out period 256 with no runt pulse; timeout_err=0.
REQ-037 Request sel=cur_sel=3 -> done=1 exactly one cycle after accept, no gap in clk_out.
REQ-038 TIMEOUT=16, taps[0] held 1, request sel=3 from 0 -> SWITCH on 16th WAIT_LOW cycle, done 17 cycles after accept, timeout_err=1 until rst.
REQ-039 Macro defined, sel=1, en=1 for 400 cycles after cnt_clr -> edge_cnt=100; cnt_clr coincident with out_rise -> edge_cnt=0.
REQ-040 rst pulsed mid WAIT_LOW (request 0->5) -> cur_sel=0, no done, clk_out=0 during reset, sel_ready=1 the cycle after.
